// File: rtl/mm_sram_port_if.sv
// Requester-side bundle for mm_sram_port_ctrl: loader (a), compute reader A (b)
// on macro port 0, compute reader B (c) on macro port 1, plus read returns.
interface mm_sram_port_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 128
);
    logic              a_valid;
    logic              a_ready;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_rvalid;

    logic              b_valid;
    logic              b_ready;
    logic [ADDR_W-1:0] b_addr;
    logic              b_rvalid;

    logic              c_valid;
    logic              c_ready;
    logic [ADDR_W-1:0] c_addr;
    logic              c_rvalid;

    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;

    modport master (
        output a_valid, a_we, a_addr, a_wdata,
        output b_valid, b_addr,
        output c_valid, c_addr,
        input  a_ready, a_rvalid, b_ready, b_rvalid, c_ready, c_rvalid,
        input  rdata0, rdata1
    );

    modport slave (
        input  a_valid, a_we, a_addr, a_wdata,
        input  b_valid, b_addr,
        input  c_valid, c_addr,
        output a_ready, a_rvalid, b_ready, b_rvalid, c_ready, c_rvalid,
        output rdata0, rdata1
    );
endinterface

// File: rtl/mm_sram_port_ctrl.sv
// Port controller for the 1RW/1R SRAM macro: round-robin port-0 sharing, port-1 reader,
// read-latency tracking. Define MM_SRAM_FWD_EN to forward write data on a port-1 collision.
module mm_sram_port_ctrl #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 128,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    mm_sram_port_if.slave     bus,
    output logic              csb0,
    output logic              web0,
    output logic [ADDR_W-1:0] addr0,
    output logic [DATA_W-1:0] din0,
    input  logic [DATA_W-1:0] dout0,
    output logic              csb1,
    output logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] dout1
);

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_t;

    grant_t last_grant;
    grant_t last_grant_nxt;
    logic   a_fire;
    logic   b_fire;
    logic   c_fire;
    logic   collision;
    logic   rd0_fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= GRANT_B;
        end else begin
            last_grant <= last_grant_nxt;
        end
    end

    // Grants are gated by rst_n so nothing is accepted while reset is held.
    always_comb begin
        a_fire         = 1'b0;
        b_fire         = 1'b0;
        last_grant_nxt = last_grant;
        if (rst_n) begin
            if (bus.a_valid && (!bus.b_valid || last_grant == GRANT_B)) begin
                a_fire = 1'b1;
            end else if (bus.b_valid) begin
                b_fire = 1'b1;
            end
        end
        if (a_fire) begin
            last_grant_nxt = GRANT_A;
        end else if (b_fire) begin
            last_grant_nxt = GRANT_B;
        end
    end

    assign bus.a_ready = a_fire;
    assign bus.b_ready = b_fire;

    assign csb0  = ~(a_fire | b_fire);
    assign web0  = ~(a_fire & bus.a_we);
    assign addr0 = a_fire ? bus.a_addr : (b_fire ? bus.b_addr : '0);
    assign din0  = (a_fire && bus.a_we) ? bus.a_wdata : '0;

    assign collision = bus.c_valid & a_fire & bus.a_we & (bus.c_addr == bus.a_addr);

`ifdef MM_SRAM_FWD_EN
    assign bus.c_ready = rst_n;
`else
    assign bus.c_ready = rst_n & ~collision;
`endif

    assign c_fire = bus.c_valid & bus.c_ready;
    assign csb1   = ~c_fire;
    assign addr1  = rst_n ? bus.c_addr : '0;

    assign rd0_fire = (a_fire & ~bus.a_we) | b_fire;

    // Return pipelines: entry 0 loads on the accepting edge, entry READ_LAT-1 is the response.
    logic [READ_LAT-1:0] vld0_p;
    logic [READ_LAT-1:0] id0_p;
    logic [READ_LAT-1:0] vld1_p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld0_p <= '0;
            id0_p  <= '0;
            vld1_p <= '0;
        end else begin
            vld0_p[0] <= rd0_fire;
            id0_p[0]  <= b_fire;
            vld1_p[0] <= c_fire;
            for (int i = 1; i < READ_LAT; i++) begin
                vld0_p[i] <= vld0_p[i-1];
                id0_p[i]  <= id0_p[i-1];
                vld1_p[i] <= vld1_p[i-1];
            end
        end
    end

    assign bus.a_rvalid = vld0_p[READ_LAT-1] & ~id0_p[READ_LAT-1];
    assign bus.b_rvalid = vld0_p[READ_LAT-1] &  id0_p[READ_LAT-1];
    assign bus.c_rvalid = vld1_p[READ_LAT-1];
    assign bus.rdata0   = dout0;

`ifdef MM_SRAM_FWD_EN
    logic [READ_LAT-1:0] fwd1_p;
    logic [DATA_W-1:0]   fwd_data_p [READ_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd1_p <= '0;
        end else begin
            fwd1_p[0] <= collision;
            for (int i = 1; i < READ_LAT; i++) begin
                fwd1_p[i] <= fwd1_p[i-1];
            end
        end
    end

    // Data-only stage: qualified by fwd1_p, so it needs no reset.
    always_ff @(posedge clk) begin
        fwd_data_p[0] <= bus.a_wdata;
        for (int i = 1; i < READ_LAT; i++) begin
            fwd_data_p[i] <= fwd_data_p[i-1];
        end
    end

    assign bus.rdata1 = fwd1_p[READ_LAT-1] ? fwd_data_p[READ_LAT-1] : dout1;
`else
    assign bus.rdata1 = dout1;
`endif

endmodule

// File: tb/tb_mm_sram_port_ctrl.sv
// Bench for mm_sram_port_ctrl: behavioural SRAM macro, response-queue reference model,
// directed steps followed by randomized traffic.
module tb_mm_sram_port_ctrl;

    localparam int AW  = 8;
    localparam int DW  = 128;
    localparam int LAT = 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          csb0, web0, csb1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] din0, dout0, dout1;

    mm_sram_port_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mm_sram_port_ctrl #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .csb0  (csb0),
        .web0  (web0),
        .addr0 (addr0),
        .din0  (din0),
        .dout0 (dout0),
        .csb1  (csb1),
        .addr1 (addr1),
        .dout1 (dout1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural macro: port 0 read/write, port 1 read, read-before-write on the same edge.
    logic [DW-1:0] mem [256];
    logic [DW-1:0] d0_pipe [LAT];
    logic [DW-1:0] d1_pipe [LAT];
    always @(posedge clk) begin
        if (!csb0 && !web0) mem[addr0] <= din0;
        d0_pipe[0] <= (!csb0 && web0) ? mem[addr0] : {DW{1'bx}};
        d1_pipe[0] <= (!csb1) ? mem[addr1] : {DW{1'bx}};
        for (int i = 1; i < LAT; i++) begin
            d0_pipe[i] <= d0_pipe[i-1];
            d1_pipe[i] <= d1_pipe[i-1];
        end
    end
    assign dout0 = d0_pipe[LAT-1];
    assign dout1 = d1_pipe[LAT-1];

    // Reference model state
    typedef struct {
        int      due;
        logic [DW-1:0] data;
    } rsp_t;
    rsp_t          qa[$];
    rsp_t          qb[$];
    rsp_t          qc[$];
    logic [DW-1:0] ref_mem [256];
    logic          last_a;
    int            ncmp = 0;
    int            nfail = 0;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rsp(input string tag, input logic rv, input logic [DW-1:0] rd,
                           input logic ev, input logic [DW-1:0] ed);
        chk1({tag, "_rvalid"}, rv, ev);
        if (ev) chkw({tag, "_rdata"}, rd, ed);
    endtask

    task automatic check_returns();
        logic          ev;
        logic [DW-1:0] ed;
        ev = (qa.size() > 0) && (qa[0].due == cyc);
        ed = ev ? qa[0].data : '0;
        chk_rsp("a", bus.a_rvalid, bus.rdata0, ev, ed);
        if (qa.size() > 0 && qa[0].due <= cyc) void'(qa.pop_front());
        ev = (qb.size() > 0) && (qb[0].due == cyc);
        ed = ev ? qb[0].data : '0;
        chk_rsp("b", bus.b_rvalid, bus.rdata0, ev, ed);
        if (qb.size() > 0 && qb[0].due <= cyc) void'(qb.pop_front());
        ev = (qc.size() > 0) && (qc[0].due == cyc);
        ed = ev ? qc[0].data : '0;
        chk_rsp("c", bus.c_rvalid, bus.rdata1, ev, ed);
        if (qc.size() > 0 && qc[0].due <= cyc) void'(qc.pop_front());
    endtask

    // One cycle: check returns, drive requests, predict handshakes and future responses.
    task automatic step(input logic av, input logic awe, input logic [AW-1:0] aa,
                        input logic [DW-1:0] ad, input logic bv, input logic [AW-1:0] ba,
                        input logic cv, input logic [AW-1:0] ca);
        logic ea, eb, ec, coll, cr;
        rsp_t r;
        @(negedge clk);
        check_returns();
        bus.a_valid = av;  bus.a_we = awe;  bus.a_addr = aa;  bus.a_wdata = ad;
        bus.b_valid = bv;  bus.b_addr = ba;
        bus.c_valid = cv;  bus.c_addr = ca;
        #1;
        ea   = av && (!bv || !last_a);
        eb   = bv && !ea;
        coll = cv && ea && awe && (ca == aa);
`ifdef MM_SRAM_FWD_EN
        cr = 1'b1;
`else
        cr = !coll;
`endif
        ec = cv && cr;
        chk1("a_ready", bus.a_ready, ea);
        chk1("b_ready", bus.b_ready, eb);
        chk1("c_ready", bus.c_ready, cr);
        chk1("csb0", csb0, !(ea || eb));
        chk1("web0", web0, !(ea && awe));
        chk1("csb1", csb1, !ec);
        if (ea || eb) chkw("addr0", 128'(addr0), 128'(ea ? aa : ba));
        if (ea && awe) chkw("din0", din0, ad);
        if (ec) chkw("addr1", 128'(addr1), 128'(ca));
        if (ea || eb) last_a = ea;
        r.due = cyc + LAT;
        if (ec) begin
            r.data = coll ? ad : ref_mem[ca];
            qc.push_back(r);
        end
        if (ea && !awe) begin
            r.data = ref_mem[aa];
            qa.push_back(r);
        end
        if (eb) begin
            r.data = ref_mem[ba];
            qb.push_back(r);
        end
        if (ea && awe) ref_mem[aa] = ad;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, '0, 0, '0);
    endtask

    function automatic logic [DW-1:0] rnd_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check_reset_state();
        chk1("rst_a_ready", bus.a_ready, 1'b0);
        chk1("rst_b_ready", bus.b_ready, 1'b0);
        chk1("rst_c_ready", bus.c_ready, 1'b0);
        chk1("rst_csb0", csb0, 1'b1);
        chk1("rst_web0", web0, 1'b1);
        chkw("rst_addr0", 128'(addr0), '0);
        chkw("rst_din0", din0, '0);
        chk1("rst_csb1", csb1, 1'b1);
        chkw("rst_addr1", 128'(addr1), '0);
        chk1("rst_a_rvalid", bus.a_rvalid, 1'b0);
        chk1("rst_b_rvalid", bus.b_rvalid, 1'b0);
        chk1("rst_c_rvalid", bus.c_rvalid, 1'b0);
    endtask

    initial begin
        logic [DW-1:0] w;
        rst_n = 1'b0;
        last_a = 1'b0;
        bus.a_valid = 1'b1;  bus.a_we = 1'b1;  bus.a_addr = 8'h11;  bus.a_wdata = '1;
        bus.b_valid = 1'b1;  bus.b_addr = 8'h22;
        bus.c_valid = 1'b1;  bus.c_addr = 8'h33;
        for (int i = 0; i < 256; i++) ref_mem[i] = 'x;

        // Reset held with every requester asking
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_state();
        rst_n = 1'b1;
        bus.a_valid = 1'b0;  bus.b_valid = 1'b0;  bus.c_valid = 1'b0;

        // First tie after reset goes to a (a writes, b reads after)
        w = rnd_word();
        step(1, 1, 8'h05, w, 1, 8'h06, 0, '0);
        step(0, 0, '0, '0, 1, 8'h05, 0, '0);

        // Fill the whole array through the loader
        for (int i = 0; i < 256; i++) step(1, 1, AW'(i), rnd_word(), 0, '0, 0, '0);

        // Write then read 0x10
        step(1, 1, 8'h10, {16{8'hA5}}, 0, '0, 0, '0);
        step(1, 0, 8'h10, '0, 0, '0, 0, '0);
        idle(LAT + 1);

        // Sustained a/b contention
        for (int i = 0; i < 6; i++) step(1, 0, 8'h01, '0, 1, 8'h02, 0, '0);
        idle(LAT + 1);

        // Read 0x20 then write it in the next cycle: read sees old data
        step(1, 0, 8'h20, '0, 0, '0, 0, '0);
        step(1, 1, 8'h20, rnd_word(), 0, '0, 0, '0);

        // Port-1 sweep with port 0 idle
        for (int i = 0; i < 256; i++) step(0, 0, '0, '0, 0, '0, 1, AW'(i));
        idle(LAT + 1);

        // Collision: a writes 0x3C while c reads it, then c keeps asking
        step(1, 1, 8'h3C, {16{8'h55}}, 0, '0, 1, 8'h3C);
        step(0, 0, '0, '0, 0, '0, 1, 8'h3C);
        idle(LAT + 1);

        // Reset one cycle after a read is accepted
        step(1, 0, 8'h40, '0, 1, 8'h41, 1, 8'h42);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.a_valid = 1'b1;  bus.b_valid = 1'b1;  bus.c_valid = 1'b1;
        #1;
        check_reset_state();
        qa.delete();  qb.delete();  qc.delete();
        last_a = 1'b0;
        @(negedge clk);
        check_reset_state();
        rst_n = 1'b1;
        bus.a_valid = 1'b0;  bus.b_valid = 1'b0;  bus.c_valid = 1'b0;
        idle(LAT + 1);
        step(1, 0, 8'h07, '0, 1, 8'h08, 0, '0);
        step(0, 0, '0, '0, 1, 8'h08, 0, '0);
        idle(LAT + 1);

        // Randomized traffic on a narrow address window to force collisions and ties
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom), 1'($urandom), AW'($urandom_range(0, 7)), rnd_word(),
                 1'($urandom), AW'($urandom_range(0, 7)),
                 1'($urandom), AW'($urandom_range(0, 7)));
        end
        idle(LAT + 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
